// File: rtl/module_led_ctrl.sv
// module_led_ctrl: configurable 4-LED animation controller (static/blink/chase/count).
// Revision 1.0
`default_nettype none

module module_led_ctrl #(
  parameter int TICK_DIV = 27000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [1:0] cfg_mode,
  input  logic [3:0] cfg_pattern,
  output logic [3:0] pattern,
  output logic       step_pulse
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_BLINK  = 2'b01;
  localparam logic [1:0] MODE_CHASE  = 2'b10;
  localparam logic [1:0] MODE_COUNT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   presc;
  logic [1:0]      mode_q;
  logic [3:0]      seed;
  logic            phase;
  logic            transfer;
  logic            tick;

  assign transfer = cfg_valid & cfg_ready;
  assign tick     = (state == RUN) & en & (presc == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A new configuration always wins, including over a coincident tick.
  always_comb begin
    state_nxt = state;
    if (transfer) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        LOAD:    state_nxt = RUN;
        RUN:     state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready  <= 1'b0;
      step_pulse <= 1'b0;
      pattern    <= 4'b0000;
      presc      <= '0;
      mode_q     <= 2'b00;
      seed       <= 4'b0000;
      phase      <= 1'b0;
    end else begin
      cfg_ready  <= (state_nxt != LOAD);
      step_pulse <= tick & ~transfer;
      if (transfer) begin
        mode_q  <= cfg_mode;
        pattern <= cfg_pattern;
        seed    <= cfg_pattern;
        phase   <= 1'b0;
        presc   <= '0;
      end else if (state == IDLE) begin
        pattern <= 4'b0000;
        presc   <= '0;
      end else if (state == RUN && en) begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) begin
          case (mode_q)
            MODE_STATIC: pattern <= pattern;
            MODE_BLINK: begin
              phase   <= ~phase;
              pattern <= phase ? seed : 4'b0000;
            end
            MODE_CHASE:  pattern <= {pattern[2:0], pattern[3]};
            MODE_COUNT:  pattern <= pattern + 4'd1;
            default:     pattern <= pattern;
          endcase
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_module_led_ctrl.sv
// tb_module_led_ctrl: scoreboard bench for module_led_ctrl with a cycle-level reference model.
`default_nettype none

module tb_module_led_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_mode = 2'b00;
  logic [3:0] cfg_pattern = 4'b0000;
  logic       cfg_ready;
  logic [3:0] pattern;
  logic       step_pulse;

  module_led_ctrl #(.TICK_DIV(TD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_mode   (cfg_mode),
    .cfg_pattern(cfg_pattern),
    .pattern    (pattern),
    .step_pulse (step_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] pat;
    logic       pulse;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // Reference model: animation described as "enabled run cycles elapsed".
  bit m_started, m_active, m_loading, m_phase;
  int m_runs, m_mode, m_pat, m_seed;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_started = 0; m_active = 0; m_loading = 0; m_phase = 0;
    m_runs = 0; m_mode = 0; m_pat = 0; m_seed = 0;
  endfunction

  function automatic bit model_tick_next(input bit en_v);
    return m_active && !m_loading && en_v && ((m_runs % TD) == TD - 1);
  endfunction

  task automatic model_edge(input bit v, input int md, input int pt, input bit en_v);
    bit rdy, xfer, tk, pulse;
    rdy   = m_started && !m_loading;
    xfer  = v && rdy;
    tk    = model_tick_next(en_v);
    pulse = 0;
    if (xfer) begin
      m_mode = md; m_pat = pt; m_seed = pt; m_phase = 0;
      m_loading = 1; m_runs = 0; m_active = 1;
    end else if (m_loading) begin
      m_loading = 0;
    end else if (m_active && en_v) begin
      if (tk) begin
        pulse = 1;
        case (m_mode)
          1: begin m_phase = !m_phase; m_pat = m_phase ? 0 : m_seed; end
          2: m_pat = ((m_pat * 2) % 16) + (m_pat / 8);
          3: m_pat = (m_pat + 1) % 16;
          default: ;
        endcase
      end
      m_runs++;
    end
    m_started = 1;
    q.push_back(exp_t'({4'(m_pat), pulse, !m_loading}));
  endtask

  task automatic cyc(input bit v, input int md, input int pt, input bit en_v);
    @(negedge clk);
    cfg_valid   = v;
    cfg_mode    = md[1:0];
    cfg_pattern = pt[3:0];
    en          = en_v;
    @(posedge clk);
    if (rst_n) model_edge(v, md, pt, en_v);
  endtask

  task automatic reset_mid();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pattern", 8'(pattern), 8'd0);
    check("async_rst_pulse", 8'(step_pulse), 8'd0);
    check("async_rst_ready", 8'(cfg_ready), 8'd0);
    q.delete();
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("pattern", 8'(pattern), 8'(e.pat));
      check("step_pulse", 8'(step_pulse), 8'(e.pulse));
      check("cfg_ready", 8'(cfg_ready), 8'(e.rdy));
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_pattern", 8'(pattern), 8'd0);
    check("rst_pulse", 8'(step_pulse), 8'd0);
    check("rst_ready", 8'(cfg_ready), 8'd0);
    rst_n = 1'b1;

    repeat (50) cyc(0, 0, 0, 1);
    // STATIC 1010
    cyc(1, 0, 10, 1);
    repeat (14) cyc(0, 0, 0, 1);
    // CHASE 0001 with a 3-cycle enable gap
    cyc(1, 2, 1, 1);
    repeat (10) cyc(0, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0);
    repeat (12) cyc(0, 0, 0, 1);
    // COUNT 1110 then BLINK 0110
    cyc(1, 3, 14, 1);
    repeat (16) cyc(0, 0, 0, 1);
    cyc(1, 1, 6, 1);
    repeat (12) cyc(0, 0, 0, 1);
    // COUNT 0000, then a new config landing exactly on a tick
    cyc(1, 3, 0, 1);
    for (int i = 0; i < 20 && !model_tick_next(1); i++) cyc(0, 0, 0, 1);
    cyc(1, 1, 5, 1);
    repeat (12) cyc(0, 0, 0, 1);
    // Async reset during CHASE; pattern must stay clear afterwards
    cyc(1, 2, 3, 1);
    repeat (6) cyc(0, 0, 0, 1);
    reset_mid();
    repeat (12) cyc(0, 0, 0, 1);
    // Randomized traffic
    repeat (800) cyc($urandom_range(0, 9) == 0, $urandom_range(0, 3),
                     $urandom_range(0, 15), $urandom_range(0, 7) != 0);
    cyc(1, 1, 9, 1);
    repeat (10) cyc($urandom_range(0, 1) == 1, $urandom_range(0, 3),
                    $urandom_range(0, 15), 1);
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 8'(q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
